// File: rtl/pulse_train_pkg.sv
// Shared state encoding and simulation helpers for pulse_train_gen.
package pulse_train_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        SIDLE = 2'd0,
        SHIGH = 2'd1,
        SLOW  = 2'd2,
        SDONE = 2'd3
    } state_t;

    // Readable state name for simulation display.
    function automatic string state_name(input state_t s);
        case (s)
            SIDLE:   return "SIDLE";
            SHIGH:   return "SHIGH";
            SLOW:    return "SLOW";
            SDONE:   return "SDONE";
            default: return "UNKNOWN";
        endcase
    endfunction

endpackage

// File: rtl/pulse_train_gen_phase_counter.sv
// Loadable down-counter timing one high or low phase; zero_c flags the last cycle.
module phase_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt;

    // Load takes priority over decrement; the counter holds at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: NUM_PULSES pulses of HIGH_CYC clocks separated by
// LOW_CYC clocks, with busy/done handshake.
// Optional continuous mode (NUM_PULSES=0 repeats until STOP) when
// PULSE_TRAIN_CONTINUOUS_EN is defined.
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned NUM_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic [CNT_W-1:0] HIGH_CYC,
    input  logic [CNT_W-1:0] LOW_CYC,
    input  logic [NUM_W-1:0] NUM_PULSES,
    output logic             PULSE,
    output logic             BUSY,
    output logic             DONE,
    output logic [NUM_W-1:0] PULSE_IDX
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] high_sh;
    logic [CNT_W-1:0] low_sh;
    logic [NUM_W-1:0] num_sh;
    logic [NUM_W-1:0] idx_nxt;
    logic [NUM_W-1:0] idx_inc;
    logic             last_pulse;
    logic             zero_start;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_zero;

    // Counter reload value for a phase; a zero length counts as one clock.
    function automatic logic [CNT_W-1:0] phase_last(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

`ifdef PULSE_TRAIN_CONTINUOUS_EN
    // Captured count of zero never ends the train; the index saturates.
    assign idx_inc    = (PULSE_IDX == '1) ? PULSE_IDX : PULSE_IDX + NUM_W'(1);
    assign last_pulse = (num_sh != '0) && (idx_inc == num_sh);
    assign zero_start = 1'b0;
`else
    assign idx_inc    = PULSE_IDX + NUM_W'(1);
    assign last_pulse = (idx_inc == num_sh);
    assign zero_start = (NUM_PULSES == '0);
`endif

    phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero_c   (cnt_zero)
    );

    // Next-state, pulse index and phase counter control.
    always_comb begin
        state_nxt = state;
        idx_nxt   = PULSE_IDX;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;
        case (state)
            SIDLE: begin
                if (START) begin
                    idx_nxt = '0;
                    if (zero_start) begin
                        state_nxt = SDONE;
                    end else begin
                        state_nxt = SHIGH;
                        cnt_load  = 1'b1;
                        cnt_val   = phase_last(HIGH_CYC);
                    end
                end
            end
            SHIGH: begin
                if (cnt_zero) begin
                    // The pulse completes on this cycle even if STOP is present.
                    idx_nxt = idx_inc;
                    if (STOP || last_pulse) begin
                        state_nxt = SDONE;
                    end else begin
                        state_nxt = SLOW;
                        cnt_load  = 1'b1;
                        cnt_val   = phase_last(low_sh);
                    end
                end else if (STOP) begin
                    state_nxt = SDONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            SLOW: begin
                if (STOP) begin
                    state_nxt = SDONE;
                end else if (cnt_zero) begin
                    state_nxt = SHIGH;
                    cnt_load  = 1'b1;
                    cnt_val   = phase_last(high_sh);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            SDONE: begin
                state_nxt = SIDLE;
            end
            default: begin
                state_nxt = SIDLE;
            end
        endcase
    end

    // State, shadow registers and outputs decoded from the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= SIDLE;
            high_sh   <= '0;
            low_sh    <= '0;
            num_sh    <= '0;
            PULSE_IDX <= '0;
            PULSE     <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            if ((state == SIDLE) && START) begin
                high_sh <= HIGH_CYC;
                low_sh  <= LOW_CYC;
                num_sh  <= NUM_PULSES;
            end
            state     <= state_nxt;
            PULSE_IDX <= idx_nxt;
            PULSE     <= (state_nxt == SHIGH);
            BUSY      <= (state_nxt == SHIGH) || (state_nxt == SLOW);
            DONE      <= (state_nxt == SDONE);
        end
    end

endmodule
